// File: rtl/rabbit_keystream_out_if.sv
// Handshake bundle for rabbit_keystream_out: state-word input side and keystream output side.
// The din lane exists only when RABBIT_XOR_EN is defined.
interface rabbit_keystream_out_if;
    logic [31:0] X0_in;
    logic [31:0] X1_in;
    logic [31:0] X2_in;
    logic [31:0] X3_in;
    logic [31:0] X4_in;
    logic [31:0] X5_in;
    logic [31:0] X6_in;
    logic [31:0] X7_in;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] ks_word;
    logic        ks_valid;
    logic        ks_ready;
    logic [1:0]  ks_idx;
    logic        ks_last;
`ifdef RABBIT_XOR_EN
    logic [31:0] din;
`endif

    modport slave (
        input  X0_in, X1_in, X2_in, X3_in, X4_in, X5_in, X6_in, X7_in,
        input  in_valid, flush, ks_ready,
`ifdef RABBIT_XOR_EN
        input  din,
`endif
        output in_ready, ks_word, ks_valid, ks_idx, ks_last
    );

    modport master (
        output X0_in, X1_in, X2_in, X3_in, X4_in, X5_in, X6_in, X7_in,
        output in_valid, flush, ks_ready,
`ifdef RABBIT_XOR_EN
        output din,
`endif
        input  in_ready, ks_word, ks_valid, ks_idx, ks_last
    );
endinterface

// File: rtl/rabbit_keystream_out.sv
// Rabbit output stage: extracts the 128-bit S block from the state words and streams it as four 32-bit words.
// Optional macro RABBIT_XOR_EN: XOR each word with din, turning the block into an encrypt/decrypt stage.
module rabbit_keystream_out (
    input  logic                  clk,
    input  logic                  rst,
    rabbit_keystream_out_if.slave bus
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state_q, state_d;
    logic [127:0] s_q, s_d;
    logic [1:0]   idx_q, idx_d;
    logic         accept;
    logic [31:0]  s_word;

    function automatic logic [127:0] extract_s(
        input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2, input logic [31:0] x3,
        input logic [31:0] x4, input logic [31:0] x5, input logic [31:0] x6, input logic [31:0] x7
    );
        logic [127:0] s;
        s[15:0]    = x0[15:0]  ^ x5[31:16];
        s[31:16]   = x0[31:16] ^ x3[15:0];
        s[47:32]   = x2[15:0]  ^ x7[31:16];
        s[63:48]   = x2[31:16] ^ x5[15:0];
        s[79:64]   = x4[15:0]  ^ x1[31:16];
        s[95:80]   = x4[31:16] ^ x7[15:0];
        s[111:96]  = x6[15:0]  ^ x3[31:16];
        s[127:112] = x6[31:16] ^ x1[15:0];
        return s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
        end
    end

    assign accept = bus.in_valid & bus.in_ready;

    // In EMIT ks_valid is always high, so a handshake reduces to ks_ready.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        idx_d   = idx_q;
        if (bus.flush) begin
            state_d = IDLE;
            s_d     = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = EMIT;
                        s_d     = extract_s(bus.X0_in, bus.X1_in, bus.X2_in, bus.X3_in,
                                            bus.X4_in, bus.X5_in, bus.X6_in, bus.X7_in);
                        idx_d   = '0;
                    end
                end
                EMIT: begin
                    if (bus.ks_ready) begin
                        if (idx_q == 2'd3) begin
                            idx_d = '0;
                            if (accept) begin
                                s_d = extract_s(bus.X0_in, bus.X1_in, bus.X2_in, bus.X3_in,
                                                bus.X4_in, bus.X5_in, bus.X6_in, bus.X7_in);
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        s_word       = s_q[{idx_q, 5'b00000} +: 32];
        bus.ks_valid = (state_q == EMIT);
        bus.ks_idx   = idx_q;
        bus.ks_last  = (state_q == EMIT) & (idx_q == 2'd3);
        bus.in_ready = ((state_q == IDLE) |
                        ((state_q == EMIT) & (idx_q == 2'd3) & bus.ks_ready)) & ~bus.flush;
`ifdef RABBIT_XOR_EN
        bus.ks_word  = s_word ^ bus.din;
`else
        bus.ks_word  = s_word;
`endif
    end

endmodule

// File: tb/tb_rabbit_keystream_out.sv
// Directed bench for rabbit_keystream_out: vector table for streaming/backpressure/back-to-back/flush,
// plus hand sequences for reset state, async reset mid-block and the XOR build.
module tb_rabbit_keystream_out;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    rabbit_keystream_out_if bus();

    rabbit_keystream_out dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        fl;
        logic        rdy;
        logic [1:0]  blk;
        logic        ev;
        logic [1:0]  eidx;
        logic [31:0] ew;
        logic        el;
        logic        eir;
        logic        cw;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Block 1 -> words 55554761,0,0,0 ; block 2 -> words 0,33334444,00001111,22220000
    task automatic set_blk(input logic [1:0] b);
        bus.X0_in = 32'h0; bus.X1_in = 32'h0; bus.X2_in = 32'h0; bus.X3_in = 32'h0;
        bus.X4_in = 32'h0; bus.X5_in = 32'h0; bus.X6_in = 32'h0; bus.X7_in = 32'h0;
        if (b == 2'd1) begin
            bus.X0_in = 32'hAAAA5555;
            bus.X3_in = 32'h0000FFFF;
            bus.X5_in = 32'h12340000;
        end else if (b == 2'd2) begin
            bus.X1_in = 32'h11112222;
            bus.X2_in = 32'h33334444;
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] raw);
`ifdef RABBIT_XOR_EN
        return raw ^ bus.din;
`else
        return raw;
`endif
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;

        //          iv    fl    rdy   blk   ev    idx   word           last  inrdy cw
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 32'h00000000, 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 32'h55554761, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd1, 32'h00000000, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd2, 32'h00000000, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd3, 32'h00000000, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 32'h00000000, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 32'h33334444, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 32'h33334444, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 32'h33334444, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd1, 32'h33334444, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd2, 32'h00001111, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 2'd3, 32'h22220000, 1'b1, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 32'h55554761, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd1, 32'h00000000, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 2'd2, 32'h00000000, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 32'h00000000, 1'b0, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 32'h33334444, 1'b0, 1'b0, 1'b1};

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.ks_ready = 1'b0;
`ifdef RABBIT_XOR_EN
        bus.din      = 32'hFFFFFFFF;
`endif
        set_blk(2'd0);

        #1;
        chk("rst_ks_valid", {31'b0, bus.ks_valid}, 32'h0);
        chk("rst_ks_idx",   {30'b0, bus.ks_idx},   32'h0);
        chk("rst_ks_last",  {31'b0, bus.ks_last},  32'h0);
        chk("rst_ks_word",  bus.ks_word, exp_word(32'h0));

        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'b0, bus.in_ready}, 32'h1);

        for (int i = 0; i < 19; i++) begin
            bus.in_valid = tbl[i].iv;
            bus.flush    = tbl[i].fl;
            bus.ks_ready = tbl[i].rdy;
            set_blk(tbl[i].blk);
            #1;
            chk($sformatf("v%0d_ks_valid", i), {31'b0, bus.ks_valid}, {31'b0, tbl[i].ev});
            chk($sformatf("v%0d_ks_idx", i),   {30'b0, bus.ks_idx},   {30'b0, tbl[i].eidx});
            chk($sformatf("v%0d_ks_last", i),  {31'b0, bus.ks_last},  {31'b0, tbl[i].el});
            chk($sformatf("v%0d_in_ready", i), {31'b0, bus.in_ready}, {31'b0, tbl[i].eir});
            if (tbl[i].ev | tbl[i].cw)
                chk($sformatf("v%0d_ks_word", i), bus.ks_word, exp_word(tbl[i].ew));
            @(posedge clk);
            #1;
        end

        // Async reset while block 2 is held at idx 1
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.ks_ready = 1'b0;
        #1;
        chk("pre_arst_ks_idx", {30'b0, bus.ks_idx}, 32'h1);
        rst = 1'b1;
        #1;
        chk("arst_ks_valid", {31'b0, bus.ks_valid}, 32'h0);
        chk("arst_ks_idx",   {30'b0, bus.ks_idx},   32'h0);
        chk("arst_ks_last",  {31'b0, bus.ks_last},  32'h0);
        chk("arst_ks_word",  bus.ks_word, exp_word(32'h0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.ks_ready = 1'b1;
        #1;
        chk("arst_rel_in_ready", {31'b0, bus.in_ready}, 32'h1);
        chk("arst_rel_ks_valid", {31'b0, bus.ks_valid}, 32'h0);
        @(posedge clk);
        #1;
        chk("arst_idle_ks_valid", {31'b0, bus.ks_valid}, 32'h0);

`ifdef RABBIT_XOR_EN
        set_blk(2'd1);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.ks_ready = 1'b0;
        bus.din      = 32'hFFFFFFFF;
        #1;
        chk("xor_enc_word0", bus.ks_word, 32'hAAAAB89E);
        bus.din = 32'hAAAAB89E;
        #1;
        chk("xor_dec_word0", bus.ks_word, 32'hFFFFFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
